// File: rtl/loader_pkg.sv
// loader_pkg -- shared types and defaults for the program loader.
//   state_e            : loader FSM states
//   DEF_BASE_ADDR      : default byte address of the first instruction word
//   DEF_TIMEOUT_CYCLES : default allowed idle cycles between accepted bytes
//   DEF_MAX_WORDS      : default largest legal word count (256-byte memory / 4)
//   word_addr()        : byte address of word k, wrapping at 256
package loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_COLLECT,
        S_WRITE,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_e;

    localparam logic [7:0] DEF_BASE_ADDR      = 8'h00;
    localparam int         DEF_TIMEOUT_CYCLES = 1024;
    localparam int         DEF_MAX_WORDS      = 64;

    // 8-bit arithmetic on purpose: the address space is 256 bytes and wraps.
    function automatic logic [7:0] word_addr(input logic [7:0] base, input logic [7:0] k);
        logic [7:0] off;
        off = k << 2;
        return base + off;
    endfunction

endpackage

// File: rtl/gap_timer.sv
// gap_timer -- counts consecutive idle cycles while the loader waits for a byte.
//   clk, clr_n : clock, asynchronous active-low reset
//   clear      : restart the count (byte accepted, or not in a waiting state)
//   count_en   : this cycle is a waiting cycle with no accepted byte
//   expired    : this is the TIMEOUT_CYCLES-th consecutive idle cycle
module gap_timer
    import loader_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic clr_n,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    // Counter only needs to reach TIMEOUT_CYCLES-1; expiry is flagged on that cycle.
    localparam int             CW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0]  LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign expired = count_en && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear)
            cnt_d = '0;
        else if (count_en && !expired)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/program_loader.sv
// program_loader -- loads a byte stream into instruction memory while holding
// the processor in clear.
// Stream: header N, 4*N big-endian payload bytes, XOR checksum of the payload.
//   clk, clr_n       : clock, asynchronous active-low reset
//   start            : begin a load (honoured only when not busy)
//   byte_valid/_data : incoming stream byte
//   byte_ready       : a byte may transfer on this edge
//   mem_wen/addr/data: one-cycle instruction-memory write per completed word
//   cpu_clr          : processor held in clear (released only on a good load)
//   busy/done/error  : load status
module program_loader
    import loader_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR      = DEF_BASE_ADDR,
    parameter int         TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int         MAX_WORDS      = DEF_MAX_WORDS
) (
    input  logic        clk,
    input  logic        clr_n,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        mem_wen,
    output logic [7:0]  mem_addr,
    output logic [31:0] mem_data,
    output logic        cpu_clr,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam logic [8:0] MAX_N = 9'(MAX_WORDS);

    state_e      state_q;
    logic [7:0]  n_q;
    logic [7:0]  word_idx_q;
    logic [1:0]  byte_idx_q;
    logic [23:0] shift_q;      // first three bytes of the word in flight
    logic [7:0]  csum_q;
    logic [7:0]  mem_addr_q;
    logic [31:0] mem_data_q;

    logic waiting, accept, gap_expired;

    assign waiting = (state_q == S_HDR) || (state_q == S_COLLECT) || (state_q == S_CHECK);
    assign accept  = waiting && byte_valid;

    gap_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_gap (
        .clk      (clk),
        .clr_n    (clr_n),
        .clear    (accept || !waiting),
        .count_en (waiting && !accept),
        .expired  (gap_expired)
    );

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q    <= S_IDLE;
            n_q        <= '0;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            shift_q    <= '0;
            csum_q     <= '0;
            mem_addr_q <= BASE_ADDR;
            mem_data_q <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        state_q    <= S_HDR;
                        word_idx_q <= '0;
                        byte_idx_q <= '0;
                        csum_q     <= '0;
                    end
                end
                S_HDR: begin
                    if (accept) begin
                        n_q <= byte_data;
                        if (byte_data == 8'd0)
                            state_q <= S_CHECK;
                        else if ({1'b0, byte_data} > MAX_N)
                            state_q <= S_ERROR;
                        else
                            state_q <= S_COLLECT;
                    end else if (gap_expired) begin
                        state_q <= S_ERROR;
                    end
                end
                S_COLLECT: begin
                    if (accept) begin
                        shift_q    <= {shift_q[15:0], byte_data};
                        csum_q     <= csum_q ^ byte_data;
                        byte_idx_q <= byte_idx_q + 2'd1;
                        // Word complete: latch address/data so they are stable for the WRITE cycle.
                        if (byte_idx_q == 2'd3) begin
                            mem_data_q <= {shift_q, byte_data};
                            mem_addr_q <= word_addr(BASE_ADDR, word_idx_q);
                            state_q    <= S_WRITE;
                        end
                    end else if (gap_expired) begin
                        state_q <= S_ERROR;
                    end
                end
                S_WRITE: begin
                    word_idx_q <= word_idx_q + 8'd1;
                    if ((word_idx_q + 8'd1) < n_q)
                        state_q <= S_COLLECT;
                    else
                        state_q <= S_CHECK;
                end
                S_CHECK: begin
                    if (accept)
                        state_q <= (byte_data == csum_q) ? S_DONE : S_ERROR;
                    else if (gap_expired)
                        state_q <= S_ERROR;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Control outputs are pure decodes of the state register, so reset reaches them asynchronously.
    assign byte_ready = waiting;
    assign mem_wen    = (state_q == S_WRITE);
    assign busy       = waiting || (state_q == S_WRITE);
    assign done       = (state_q == S_DONE);
    assign error      = (state_q == S_ERROR);
    assign cpu_clr    = (state_q != S_DONE);
    assign mem_addr   = mem_addr_q;
    assign mem_data   = mem_data_q;

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

    localparam logic [7:0] BASE = 8'h00;
    localparam int         T    = 16;
    localparam int         MAXW = 64;

    logic        clk = 1'b0;
    logic        clr_n = 1'b1;
    logic        start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_ready, mem_wen, cpu_clr, busy, done, error;
    logic [7:0]  mem_addr;
    logic [31:0] mem_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    program_loader #(
        .BASE_ADDR(BASE), .TIMEOUT_CYCLES(T), .MAX_WORDS(MAXW)
    ) dut (
        .clk(clk), .clr_n(clr_n), .start(start),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_data(mem_data),
        .cpu_clr(cpu_clr), .busy(busy), .done(done), .error(error)
    );

    // ---------------- behavioural stream model ----------------
    // Tracks position in the byte stream rather than any state encoding.
    bit          m_loading, m_wr;
    int          m_pos, m_n, m_gap, m_k, m_outcome;   // outcome: 0 none, 1 good, 2 aborted
    logic [7:0]  m_csum;
    logic [7:0]  m_pay [0:255];
    logic [7:0]  m_exp_addr;
    logic [31:0] m_exp_data;

    always @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            m_loading = 0; m_wr = 0; m_outcome = 0; m_pos = 0; m_gap = 0; m_k = 0; m_csum = 0;
        end else if (!m_loading) begin
            if (start) begin
                m_loading = 1; m_wr = 0; m_pos = 0; m_gap = 0; m_k = 0; m_csum = 0; m_outcome = 0;
            end
        end else if (m_wr) begin
            m_wr = 0;
            m_k++;
        end else if (byte_valid) begin
            m_gap = 0;
            if (m_pos == 0) begin
                m_n = int'(byte_data);
                m_pos = 1;
                if (m_n > MAXW) begin m_loading = 0; m_outcome = 2; end
            end else if (m_pos <= 4 * m_n) begin
                m_pay[m_pos-1] = byte_data;
                m_csum ^= byte_data;
                m_pos++;
                if ((m_pos - 1) % 4 == 0) begin
                    m_wr = 1;
                    m_exp_addr = BASE + 8'(4 * m_k);
                    m_exp_data = {m_pay[m_pos-5], m_pay[m_pos-4], m_pay[m_pos-3], m_pay[m_pos-2]};
                end
            end else begin
                m_loading = 0;
                m_outcome = (byte_data == m_csum) ? 1 : 2;
            end
        end else begin
            m_gap++;
            if (m_gap >= T) begin m_loading = 0; m_outcome = 2; end
        end
    end

    // ---------------- per-cycle compare + write log ----------------
    logic [7:0]  wr_addr_log [$];
    logic [31:0] wr_data_log [$];
    int          wen_cycles = 0;
    int          wen_rises = 0;
    logic        prev_wen = 1'b0;

    always @(negedge clk) begin
        logic e_rdy, e_wen, e_busy, e_done, e_err, e_clr;
        e_rdy  = m_loading && !m_wr;
        e_wen  = m_wr;
        e_busy = m_loading;
        e_done = !m_loading && (m_outcome == 1);
        e_err  = !m_loading && (m_outcome == 2);
        e_clr  = !e_done;
        checks++;
        if ({byte_ready, mem_wen, busy, done, error, cpu_clr} !== {e_rdy, e_wen, e_busy, e_done, e_err, e_clr}) begin
            errors++;
            $display("FAIL cycle_outputs t=%0t got rdy/wen/busy/done/err/clr=%b%b%b%b%b%b want %b%b%b%b%b%b",
                     $time, byte_ready, mem_wen, busy, done, error, cpu_clr,
                     e_rdy, e_wen, e_busy, e_done, e_err, e_clr);
        end
        if (e_wen) begin
            checks++;
            if (mem_addr !== m_exp_addr || mem_data !== m_exp_data) begin
                errors++;
                $display("FAIL write_word t=%0t got %h@%h want %h@%h",
                         $time, mem_data, mem_addr, m_exp_data, m_exp_addr);
            end
        end
        if (mem_wen === 1'b1) begin
            wr_addr_log.push_back(mem_addr);
            wr_data_log.push_back(mem_data);
            wen_cycles++;
            if (!prev_wen) wen_rises++;
        end
        prev_wen = mem_wen;
    end

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    // All tasks start and end just after a falling edge.
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int budget;
        repeat (gap) begin byte_data = 8'($urandom); @(negedge clk); end
        byte_valid = 1'b1;
        byte_data  = b;
        budget = 0;
        while (byte_ready !== 1'b1 && budget < 300) begin @(negedge clk); budget++; end
        if (budget >= 300) begin
            checks++; errors++;
            $display("FAIL byte_accept_timeout byte=%h got ready=%b want 1", b, byte_ready);
        end
        @(negedge clk);
        byte_valid = 1'b0;
        byte_data  = 8'($urandom);
    endtask

    task automatic send_seq(input logic [7:0] s [$]);
        foreach (s[i]) send_byte(s[i], 0);
    endtask

    task automatic wait_idle();
        int budget = 0;
        while (busy !== 1'b0 && budget < 100) begin @(negedge clk); budget++; end
        if (budget >= 100) begin
            checks++; errors++;
            $display("FAIL wait_idle got busy=%b want 0", busy);
        end
    endtask

    task automatic load(input int n, input bit good, input int gapmax, input bit poke_start);
        logic [7:0] cs, b;
        int nw0;
        cs  = 8'h00;
        nw0 = wr_addr_log.size();
        pulse_start();
        send_byte(8'(n), $urandom_range(0, gapmax));
        for (int i = 0; i < 4 * n; i++) begin
            b = 8'($urandom);
            cs ^= b;
            if (poke_start && i == 1) start = 1'b1;
            send_byte(b, $urandom_range(0, gapmax));
            start = 1'b0;
        end
        send_byte(good ? cs : (cs ^ 8'h5A), $urandom_range(0, gapmax));
        wait_idle();
        chk("load_done", 32'(done), 32'(good));
        chk("load_error", 32'(error), 32'(!good));
        chk("load_cpu_clr", 32'(cpu_clr), 32'(!good));
        chk("load_nwrites", 32'(wr_addr_log.size() - nw0), 32'(n));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int nw0, wc0, wr0;
        logic [7:0] seq [$];

        #1 clr_n = 1'b0;
        #1;
        chk("reset_busy", 32'(busy), 0);
        chk("reset_ready", 32'(byte_ready), 0);
        chk("reset_wen", 32'(mem_wen), 0);
        chk("reset_done_err", 32'({done, error}), 0);
        chk("reset_cpu_clr", 32'(cpu_clr), 1);
        chk("reset_addr", 32'(mem_addr), 32'(BASE));
        chk("reset_data", mem_data, 0);
        @(negedge clk);
        @(negedge clk);
        clr_n = 1'b1;
        @(negedge clk);

        // Single-word load with literal expectations.
        nw0 = wr_addr_log.size();
        pulse_start();
        seq = '{8'h01, 8'h8C, 8'h01, 8'h00, 8'h04, 8'h89};
        send_seq(seq);
        chk("one_word_done", 32'(done), 1);
        chk("one_word_cpu_clr", 32'(cpu_clr), 0);
        chk("one_word_nwrites", 32'(wr_addr_log.size() - nw0), 1);
        if (wr_addr_log.size() > nw0) begin
            chk("one_word_addr", 32'(wr_addr_log[nw0]), 32'h00);
            chk("one_word_data", wr_data_log[nw0], 32'h8C010004);
        end
        chk("model_outcome_good", 32'(m_outcome), 1);

        // Two-word load: two separate single-cycle write pulses.
        nw0 = wr_addr_log.size(); wc0 = wen_cycles; wr0 = wen_rises;
        pulse_start();
        seq = '{8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h0A, 8'h0E};
        send_seq(seq);
        chk("two_word_done", 32'(done), 1);
        chk("two_word_wen_cycles", 32'(wen_cycles - wc0), 2);
        chk("two_word_wen_pulses", 32'(wen_rises - wr0), 2);
        if (wr_addr_log.size() >= nw0 + 2) begin
            chk("two_word_addr0", 32'(wr_addr_log[nw0]), 32'h00);
            chk("two_word_data0", wr_data_log[nw0], 32'h20080005);
            chk("two_word_addr1", 32'(wr_addr_log[nw0+1]), 32'h04);
            chk("two_word_data1", wr_data_log[nw0+1], 32'h2009000A);
        end

        // Bad checksum.
        pulse_start();
        seq = '{8'h01, 8'h8C, 8'h01, 8'h00, 8'h04, 8'h00};
        send_seq(seq);
        chk("bad_csum_error", 32'(error), 1);
        chk("bad_csum_cpu_clr", 32'(cpu_clr), 1);
        chk("bad_csum_done", 32'(done), 0);
        chk("model_outcome_bad", 32'(m_outcome), 2);

        // Oversized header (65): abort with no write.
        wc0 = wen_cycles;
        pulse_start();
        seq = '{8'h41};
        send_seq(seq);
        chk("hdr65_error", 32'(error), 1);
        @(negedge clk);
        chk("hdr65_no_wen", 32'(wen_cycles - wc0), 0);

        // Gap of T-1 idle cycles is tolerated.
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'hAA, T - 1);
        send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0);
        send_byte(8'hAA ^ 8'h11 ^ 8'h22 ^ 8'h33, 0);
        chk("gap_T_minus_1_done", 32'(done), 1);

        // Stall after two payload bytes: exactly T idle cycles aborts, nothing written.
        wc0 = wen_cycles;
        pulse_start();
        send_byte(8'h01, 0); send_byte(8'h12, 0); send_byte(8'h34, 0);
        repeat (T - 1) @(negedge clk);
        chk("stall_not_yet", 32'(error), 0);
        @(negedge clk);
        chk("stall_error", 32'(error), 1);
        chk("stall_cpu_clr", 32'(cpu_clr), 1);
        chk("stall_no_wen", 32'(wen_cycles - wc0), 0);

        // Reset after three payload bytes, mid-cycle.
        wc0 = wen_cycles;
        pulse_start();
        send_byte(8'h01, 0); send_byte(8'hDE, 0); send_byte(8'hAD, 0); send_byte(8'hBE, 0);
        #2 clr_n = 1'b0;
        #1;
        chk("midreset_outputs", 32'({byte_ready, mem_wen, busy, done, error, cpu_clr}), 32'b000001);
        chk("midreset_addr", 32'(mem_addr), 32'(BASE));
        chk("midreset_data", mem_data, 0);
        @(negedge clk);
        clr_n = 1'b1;
        @(negedge clk);
        chk("midreset_no_wen", 32'(wen_cycles - wc0), 0);
        nw0 = wr_addr_log.size();
        pulse_start();
        seq = '{8'h01, 8'h8C, 8'h01, 8'h00, 8'h04, 8'h89};
        send_seq(seq);
        chk("after_reset_done", 32'(done), 1);
        if (wr_addr_log.size() > nw0)
            chk("after_reset_data", wr_data_log[nw0], 32'h8C010004);
        else
            chk("after_reset_nwrites", 32'(wr_addr_log.size() - nw0), 1);

        // Boundary word counts and randomized loads (start pokes while busy).
        load(0, 1'b1, 2, 1'b0);
        load(0, 1'b0, 2, 1'b0);
        load(MAXW, 1'b1, 1, 1'b1);
        for (int r = 0; r < 16; r++)
            load($urandom_range(1, 6), ($urandom_range(0, 3) != 0), 3, r[0]);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
